// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-port ALU sharing arbiter: ALU op encodings,
// the requester id type and the fixed ALU datapath width.
package alu_share_arbiter_pkg;

   localparam int DATA_W = 32;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SLL = 3'b001;
   localparam logic [2:0] ALU_SUB = 3'b010;
   localparam logic [2:0] ALU_SRA = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SRL = 3'b101;
   localparam logic [2:0] ALU_OR  = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b111;

   typedef logic port_id_t;

   localparam port_id_t PORT0 = 1'b0;
   localparam port_id_t PORT1 = 1'b1;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Purely combinational 32-bit integer ALU; shift amounts come from operand2[4:0].
// Zero latency, no flow control.
module alu_share_arbiter_alu
   import alu_share_arbiter_pkg::*;
(
   input  logic [DATA_W-1:0] operand1,
   input  logic [DATA_W-1:0] operand2,
   input  logic [2:0]        alusel,
   output logic [DATA_W-1:0] result
);

   logic [4:0] shamt;

   assign shamt = operand2[4:0];

   always_comb begin
      result = '0;
      case (alusel)
         ALU_ADD: result = operand1 + operand2;
         ALU_SLL: result = operand1 << shamt;
         ALU_SUB: result = operand1 - operand2;
         ALU_SRA: result = $unsigned($signed(operand1) >>> shamt);
         ALU_XOR: result = operand1 ^ operand2;
         ALU_SRL: result = operand1 >> shamt;
         ALU_OR:  result = operand1 | operand2;
         ALU_AND: result = operand1 & operand2;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two valid/ready requesters.
// One-cycle latency into a single result register; refills in the cycle it drains.
// A stalled response blocks both request ports until the owner consumes it.
module alu_share_arbiter #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_op1,
   input  logic [DATA_W-1:0] req0_op2,
   input  logic [2:0]        req0_alusel,

   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_op1,
   input  logic [DATA_W-1:0] req1_op2,
   input  logic [2:0]        req1_alusel,

   output logic              resp0_valid,
   input  logic              resp0_ready,
   output logic              resp1_valid,
   input  logic              resp1_ready,
   output logic [DATA_W-1:0] resp_result,

   output logic [CNT_W-1:0]  contention_cnt
);

   import alu_share_arbiter_pkg::*;

   logic              out_valid_q, out_valid_d;
   port_id_t          out_id_q, out_id_d;
   logic [DATA_W-1:0] result_q, result_d;
   port_id_t          last_grant_q, last_grant_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              drain;
   logic              can_accept;
   logic              grant0, grant1;
   logic              accept;
   port_id_t          accept_id;

   logic [DATA_W-1:0] alu_op1, alu_op2, alu_res;
   logic [2:0]        alu_sel;

   assign resp0_valid    = out_valid_q & (out_id_q == PORT0);
   assign resp1_valid    = out_valid_q & (out_id_q == PORT1);
   assign resp_result    = result_q;
   assign contention_cnt = cnt_q;

   // Only the owner's ready can free the register; the other port's ready is ignored.
   assign drain      = out_valid_q & ((out_id_q == PORT1) ? resp1_ready : resp0_ready);
   assign can_accept = ~out_valid_q | drain;

   // On a tie the port that did not win the last accepted operation goes next.
   assign grant0 = req0_valid & (~req1_valid | (last_grant_q == PORT1));
   assign grant1 = req1_valid & (~req0_valid | (last_grant_q == PORT0));

   // rst_n gating keeps both readies low while reset is held, independent of the clock.
   assign req0_ready = grant0 & can_accept & rst_n;
   assign req1_ready = grant1 & can_accept & rst_n;

   assign accept    = req0_ready | req1_ready;
   assign accept_id = grant1 ? PORT1 : PORT0;

   assign alu_op1 = grant1 ? req1_op1    : req0_op1;
   assign alu_op2 = grant1 ? req1_op2    : req0_op2;
   assign alu_sel = grant1 ? req1_alusel : req0_alusel;

   alu_share_arbiter_alu u_alu (
      .operand1 (alu_op1),
      .operand2 (alu_op2),
      .alusel   (alu_sel),
      .result   (alu_res)
   );

   always_comb begin
      out_valid_d  = out_valid_q;
      out_id_d     = out_id_q;
      result_d     = result_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;

      if (accept) begin
         out_valid_d  = 1'b1;
         out_id_d     = accept_id;
         result_d     = alu_res;
         last_grant_d = accept_id;
      end else if (drain) begin
         out_valid_d  = 1'b0;
      end

      if (req0_valid && req1_valid && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_id_q     <= PORT0;
         result_q     <= '0;
         last_grant_q <= PORT1;
         cnt_q        <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_id_q     <= out_id_d;
         result_q     <= result_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed table-driven bench for alu_share_arbiter plus hand-written multi-cycle sequences.
module tb_alu_share_arbiter;

   logic        clk;
   logic        rst_n;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
   logic [2:0]  req0_alusel, req1_alusel;
   logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
   logic [31:0] resp_result;
   logic [15:0] contention_cnt;

   int checks = 0;
   int errors = 0;

   alu_share_arbiter #(.DATA_W(32), .CNT_W(16)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req0_valid     (req0_valid),
      .req0_ready     (req0_ready),
      .req0_op1       (req0_op1),
      .req0_op2       (req0_op2),
      .req0_alusel    (req0_alusel),
      .req1_valid     (req1_valid),
      .req1_ready     (req1_ready),
      .req1_op1       (req1_op1),
      .req1_op2       (req1_op2),
      .req1_alusel    (req1_alusel),
      .resp0_valid    (resp0_valid),
      .resp0_ready    (resp0_ready),
      .resp1_valid    (resp1_valid),
      .resp1_ready    (resp1_ready),
      .resp_result    (resp_result),
      .contention_cnt (contention_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          rst;
      logic        r0v;
      logic [2:0]  r0s;
      logic [31:0] r0a, r0b;
      logic        r1v;
      logic [2:0]  r1s;
      logic [31:0] r1a, r1b;
      logic        p0r, p1r;
      logic        e_r0rdy, e_r1rdy, e_p0v, e_p1v;
      logic [31:0] e_res;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit rst,
                               logic r0v, logic [2:0] r0s, logic [31:0] r0a, logic [31:0] r0b,
                               logic r1v, logic [2:0] r1s, logic [31:0] r1a, logic [31:0] r1b,
                               logic p0r, logic p1r,
                               logic e_r0rdy, logic e_r1rdy, logic e_p0v, logic e_p1v,
                               logic [31:0] e_res, logic [15:0] e_cnt);
      vec_t v;
      v.rst = rst; v.r0v = r0v; v.r0s = r0s; v.r0a = r0a; v.r0b = r0b;
      v.r1v = r1v; v.r1s = r1s; v.r1a = r1a; v.r1b = r1b;
      v.p0r = p0r; v.p1r = p1r;
      v.e_r0rdy = e_r0rdy; v.e_r1rdy = e_r1rdy; v.e_p0v = e_p0v; v.e_p1v = e_p1v;
      v.e_res = e_res; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      req0_valid = 0; req0_op1 = 0; req0_op2 = 0; req0_alusel = 0;
      req1_valid = 0; req1_op1 = 0; req1_op2 = 0; req1_alusel = 0;
      resp0_ready = 0; resp1_ready = 0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   localparam logic [2:0] ADD = 3'b000, SLL = 3'b001, SUB = 3'b010, SRA = 3'b011,
                          XOR = 3'b100, SRL = 3'b101, OR_ = 3'b110, AND = 3'b111;

   initial begin
      // Reset state, with requests already presented during reset.
      rst_n = 0;
      clear_inputs();
      req0_valid = 1; req1_valid = 1;
      #1;
      chk("rst_resp0_valid", resp0_valid, 0);
      chk("rst_resp1_valid", resp1_valid, 0);
      chk("rst_result", resp_result, 0);
      chk("rst_cnt", contention_cnt, 0);
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);

      //                rst r0v op   a            b     r1v op   a            b   p0r p1r  r0r r1r p0v p1v res          cnt
      // single ADD
      tbl.push_back(mk(1, 1, ADD, 5, 7,                0, ADD, 0, 0,           1, 0,  1, 0, 0, 0, 0,            0));
      tbl.push_back(mk(0, 0, ADD, 0, 0,                0, ADD, 0, 0,           1, 0,  0, 0, 1, 0, 12,           0));
      tbl.push_back(mk(0, 0, ADD, 0, 0,                0, ADD, 0, 0,           1, 0,  0, 0, 0, 0, 12,           0));
      // tie from reset: port 0 first, then port 1
      tbl.push_back(mk(1, 1, SUB, 10, 3,               1, SRA, 32'h8000_0000, 4, 1, 1, 1, 0, 0, 0, 0,           0));
      tbl.push_back(mk(0, 0, SUB, 0, 0,                1, SRA, 32'h8000_0000, 4, 1, 1, 0, 1, 1, 0, 7,           1));
      tbl.push_back(mk(0, 0, ADD, 0, 0,                0, ADD, 0, 0,           1, 1,  0, 0, 0, 1, 32'hF800_0000, 1));
      // backpressure on port 1; port 0's ready ignored while port 1 owns the result
      tbl.push_back(mk(1, 0, ADD, 0, 0,                1, XOR, 32'hFF, 32'h0F, 0, 0,  0, 1, 0, 0, 0,            0));
      tbl.push_back(mk(0, 1, ADD, 1, 2,                0, ADD, 0, 0,           1, 0,  0, 0, 0, 1, 32'hF0,       0));
      tbl.push_back(mk(0, 1, ADD, 1, 2,                0, ADD, 0, 0,           1, 0,  0, 0, 0, 1, 32'hF0,       0));
      tbl.push_back(mk(0, 1, ADD, 1, 2,                0, ADD, 0, 0,           1, 0,  0, 0, 0, 1, 32'hF0,       0));
      tbl.push_back(mk(0, 1, ADD, 1, 2,                0, ADD, 0, 0,           1, 1,  1, 0, 0, 1, 32'hF0,       0));
      tbl.push_back(mk(0, 0, ADD, 0, 0,                0, ADD, 0, 0,           1, 0,  0, 0, 1, 0, 3,            0));
      // remaining ops back to back
      tbl.push_back(mk(1, 1, OR_, 32'hF0F0, 32'h0FF0,  0, ADD, 0, 0,           1, 0,  1, 0, 0, 0, 0,            0));
      tbl.push_back(mk(0, 1, AND, 32'hF0F0, 32'h0FF0,  0, ADD, 0, 0,           1, 0,  1, 0, 1, 0, 32'hFFF0,     0));
      tbl.push_back(mk(0, 1, SRL, 32'h8000_0000, 4,    0, ADD, 0, 0,           1, 0,  1, 0, 1, 0, 32'h00F0,     0));
      tbl.push_back(mk(0, 1, SUB, 3, 5,                0, ADD, 0, 0,           1, 0,  1, 0, 1, 0, 32'h0800_0000, 0));
      tbl.push_back(mk(0, 1, SRA, 32'h8000_0010, 36,   0, ADD, 0, 0,           1, 0,  1, 0, 1, 0, 32'hFFFF_FFFE, 0));
      tbl.push_back(mk(0, 0, ADD, 0, 0,                0, ADD, 0, 0,           1, 0,  0, 0, 1, 0, 32'hF800_0001, 0));
      // sustained tie alternates
      tbl.push_back(mk(1, 1, ADD, 1, 1,                1, ADD, 2, 2,           1, 1,  1, 0, 0, 0, 0,            0));
      tbl.push_back(mk(0, 1, ADD, 1, 1,                1, ADD, 2, 2,           1, 1,  0, 1, 1, 0, 2,            1));
      tbl.push_back(mk(0, 1, ADD, 1, 1,                1, ADD, 2, 2,           1, 1,  1, 0, 0, 1, 4,            2));
      tbl.push_back(mk(0, 0, ADD, 0, 0,                0, ADD, 0, 0,           1, 1,  0, 0, 1, 0, 2,            3));

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst) do_reset();
         req0_valid = tbl[i].r0v; req0_alusel = tbl[i].r0s; req0_op1 = tbl[i].r0a; req0_op2 = tbl[i].r0b;
         req1_valid = tbl[i].r1v; req1_alusel = tbl[i].r1s; req1_op1 = tbl[i].r1a; req1_op2 = tbl[i].r1b;
         resp0_ready = tbl[i].p0r; resp1_ready = tbl[i].p1r;
         #1;
         chk($sformatf("v%0d_req0_ready", i), req0_ready, tbl[i].e_r0rdy);
         chk($sformatf("v%0d_req1_ready", i), req1_ready, tbl[i].e_r1rdy);
         chk($sformatf("v%0d_resp0_valid", i), resp0_valid, tbl[i].e_p0v);
         chk($sformatf("v%0d_resp1_valid", i), resp1_valid, tbl[i].e_p1v);
         chk($sformatf("v%0d_result", i), resp_result, tbl[i].e_res);
         chk($sformatf("v%0d_cnt", i), contention_cnt, tbl[i].e_cnt);
         @(negedge clk);
      end

      // Streaming SLL 1,k: one accept per cycle, results in order; shift by 33 gives 2.
      do_reset();
      for (int k = 0; k <= 32; k++) begin
         logic [31:0] prev;
         req0_valid = 1; req0_alusel = SLL; req0_op1 = 1;
         req0_op2 = (k == 32) ? 32'd33 : 32'(k);
         resp0_ready = 1;
         #1;
         chk($sformatf("stream%0d_req0_ready", k), req0_ready, 1);
         if (k > 0) begin
            prev = 32'd1 << (k - 1);
            chk($sformatf("stream%0d_resp0_valid", k), resp0_valid, 1);
            chk($sformatf("stream%0d_result", k), resp_result, prev);
         end
         @(negedge clk);
      end
      req0_valid = 0;
      #1;
      chk("stream_last_result", resp_result, 2);
      chk("stream_last_valid", resp0_valid, 1);
      @(negedge clk);

      // Asynchronous reset while FULL.
      do_reset();
      req0_valid = 1; req0_alusel = ADD; req0_op1 = 32'h1000; req0_op2 = 32'h234;
      @(negedge clk);
      req0_valid = 0;
      #1;
      chk("full_resp0_valid", resp0_valid, 1);
      chk("full_result", resp_result, 32'h1234);
      req0_valid = 1; req1_valid = 1;
      #1;
      rst_n = 0;
      #1;
      chk("arst_resp0_valid", resp0_valid, 0);
      chk("arst_result", resp_result, 0);
      chk("arst_req0_ready", req0_ready, 0);
      chk("arst_req1_ready", req1_ready, 0);
      @(negedge clk);
      rst_n = 1;
      req0_valid = 1; req0_alusel = ADD; req0_op1 = 1; req0_op2 = 1;
      req1_valid = 1; req1_alusel = ADD; req1_op1 = 2; req1_op2 = 2;
      resp0_ready = 1; resp1_ready = 1;
      #1;
      chk("post_arst_req0_ready", req0_ready, 1);
      chk("post_arst_req1_ready", req1_ready, 0);
      @(negedge clk);

      // Contention counter saturation.
      do_reset();
      req0_valid = 1; req1_valid = 1; resp0_ready = 1; resp1_ready = 1;
      repeat (65534) @(posedge clk);
      #1;
      chk("cnt_fffe", contention_cnt, 16'hFFFE);
      @(posedge clk);
      #1;
      chk("cnt_ffff", contention_cnt, 16'hFFFF);
      repeat (6) @(posedge clk);
      #1;
      chk("cnt_no_wrap", contention_cnt, 16'hFFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
